// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed by a byte FIFO; frames go out LSB first,
// with one idle clock between back-to-back frames.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_tx_dv,
    input  logic [7:0]                    i_tx_byte,
    output logic                          o_tx_ready,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_uart_txd,
    output logic                          o_tx_active,
    output logic                          o_tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d, done_q, done_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            full, push, pop, wrap;

    assign full = count_q == CW'(FIFO_DEPTH);
    assign push = i_tx_dv && !full;
    assign pop  = state_q == IDLE && count_q != '0;
    assign wrap = timer_q == TW'(CLKS_PER_BIT - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pop ? START : IDLE;
            START:   state_d = wrap ? DATA : START;
            DATA:    state_d = (wrap && idx_q == 3'd7) ? STOP : DATA;
            default: state_d = wrap ? IDLE : STOP;
        endcase
    end

    always_comb begin
        o_uart_txd  = state_q == START ? 1'b0 : state_q == DATA ? shift_q[idx_q] : 1'b1;
        o_tx_active = state_q != IDLE;
    end

    // Writes are judged against the pre-edge count, so a full FIFO drops even during a pop.
    always_comb begin
        timer_d    = (state_q == IDLE || wrap) ? '0 : timer_q + 1'b1;
        idx_d      = state_q != DATA ? 3'd0 : idx_q + 3'(wrap);
        shift_d    = pop ? mem_q[rd_ptr_q] : shift_q;
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = i_tx_dv && full;
        done_d     = state_q == STOP && wrap;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer_q    <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_tx_byte;
    end

    assign o_tx_ready   = !full;
    assign o_overflow   = overflow_q;
    assign o_fifo_count = count_q;
    assign o_tx_done    = done_q;
endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clocks per serial bit; legal values are 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving the number of byte entries; legal values are powers of two, 2 or more.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_tx_dv, input, 1 bit: write strobe for i_tx_byte, sampled each rising edge.
REQ-006 SHALL have port i_tx_byte, input, 8 bits: byte to queue.
REQ-007 SHALL have port o_tx_ready, output, 1 bit: high when the FIFO is not full.
REQ-008 SHALL have port o_overflow, output, 1 bit: one-cycle pulse when a write is dropped.
REQ-009 SHALL have port o_fifo_count, output, clog2(FIFO_DEPTH)+1 bits: number of queued bytes, excluding the byte being shifted.
REQ-010 SHALL have port o_uart_txd, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port o_tx_active, output, 1 bit: high while a frame is on the line.
REQ-012 SHALL have port o_tx_done, output, 1 bit: one-cycle pulse per completed frame.

Function
REQ-013 SHALL accept a write when i_tx_dv=1 and the FIFO is not full; the byte is stored at the tail and the count increments on that edge.
REQ-014 SHALL drop a write when i_tx_dv=1 and the FIFO is full, even if a pop occurs in the same cycle; o_overflow pulses on the next cycle and FIFO contents are unchanged.
REQ-015 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-016 SHALL, in IDLE with count>0, pop the head byte into the shift register, clear the bit timer and go to START on the same edge; o_uart_txd goes low on that edge.
REQ-017 SHALL hold every bit for exactly CLKS_PER_BIT cycles, using a timer that counts 0..CLKS_PER_BIT-1 and wraps.
REQ-018 SHALL go from START to DATA and send bit 0 first (LSB first); after 8 data bits it SHALL go from DATA to STOP, with a 3-bit index counting 0..7.
REQ-019 SHALL hold o_uart_txd=1 in STOP; when the timer wraps in STOP the FSM SHALL go to IDLE and o_tx_done SHALL be 1 for exactly that one cycle in IDLE.
REQ-020 SHALL leave at least one idle clock (txd=1) between back-to-back frames; the next pop occurs on the edge after the done cycle.
REQ-021 SHALL, on a simultaneous accepted write and pop, leave o_fifo_count unchanged.
REQ-022 SHALL, when a write arrives with the FIFO empty and FSM in IDLE, start the frame one edge after the write edge (txd falls 1 cycle after the write is captured).
REQ-023 SHALL drive o_tx_active=1 in START, DATA and STOP, and 0 in IDLE.
REQ-024 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH; full is count==FIFO_DEPTH and empty is count==0.
REQ-025 SHALL ignore i_tx_byte whenever i_tx_dv=0.

Reset
REQ-026 SHALL, while i_rst=1, immediately force: FSM=IDLE, o_uart_txd=1, o_tx_active=0, o_tx_done=0, o_overflow=0, o_fifo_count=0, o_tx_ready=1, pointers and timer to 0.
REQ-027 SHALL abort a frame in progress when reset asserts mid-frame, discard queued bytes, and not pulse o_tx_done for the aborted frame.
REQ-028 SHALL accept the first write on the first rising edge after i_rst deasserts.

Verification
REQ-029 Single byte 0xAB, CLKS_PER_BIT=868, 10 ns clock -> txd bits 0,1,1,0,1,0,1,0,1,1, each 8680 ns; o_tx_done pulses 8680 cycles after txd falls.
REQ-030 Burst of 0x3F, 0x00, 0xFF on consecutive cycles -> count peaks at 2; three frames back-to-back, each separated by exactly 1 idle clock; 3 done pulses.
REQ-031 9 writes on consecutive cycles with FIFO_DEPTH=8 and the FSM idle -> first byte popped, 8 queued; o_tx_ready=0 after the 9th write; a 10th write -> o_overflow pulse, count stays 8.
REQ-032 Assert i_rst mid DATA bit 3 of 0x55 with 2 bytes queued -> txd=1 immediately, count=0, no o_tx_done; a new write after release of 0xA5 -> correct frame.
REQ-033 CLKS_PER_BIT=2, byte 0x01 -> 20-cycle frame: txd=0 for 2 cycles, 1 for 2, 0 for 14, 1 for 2; done pulse after that.
